// File: rtl/eth_tx_scheduler.sv
// Frame-level sequencer for the dibit pixel serializer: splits one BRAM frame into RMII payload
// windows, priming BRAM latency before each window and holding the inter-frame gap after it.
module eth_tx_scheduler #(
    parameter int unsigned FRAME_PIXELS      = 76800,
    parameter int unsigned PIXELS_PER_PACKET = 256,
    parameter int unsigned BRAM_LAT          = 2,
    parameter int unsigned IFG_CYCLES        = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_ready,
    input  logic        phy_busy,
    input  logic        abort,
    output logic        ser_stall,
    output logic        ser_rst,
    output logic        tx_en,
    output logic        pkt_start,
    output logic [15:0] pkt_len,
    output logic [15:0] pkt_idx,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned REM_W    = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned SEND_MAX = PIXELS_PER_PACKET * 4;
    localparam int unsigned CNT_MAX0 = (SEND_MAX > BRAM_LAT) ? SEND_MAX : BRAM_LAT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > IFG_CYCLES) ? CNT_MAX0 : IFG_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {StIdle, StWaitPhy, StPrime, StSend, StGap} state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               aborted_q, aborted_d;
    logic [15:0]        pkt_len_q, pkt_len_d;
    logic [15:0]        pkt_idx_q, pkt_idx_d;
    logic               ser_rst_q, ser_rst_d;
    logic               pkt_start_q, pkt_start_d;
    logic               frame_done_q, frame_done_d;
    logic               ser_stall_q, tx_en_q, busy_q;
    logic [15:0]        len_sel;

    // Phase counters count down to zero; the load value is the phase length minus one.
    function automatic logic [CNT_W-1:0] send_load(input logic [15:0] len);
        logic [17:0] cycles;
        cycles = {len, 2'b00} - 18'd1;
        return CNT_W'(cycles);
    endfunction

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        aborted_d    = aborted_q;
        pkt_len_d    = pkt_len_q;
        pkt_idx_d    = pkt_idx_q;
        ser_rst_d    = 1'b0;
        pkt_start_d  = 1'b0;
        frame_done_d = 1'b0;
        len_sel      = (32'(rem_q) > PIXELS_PER_PACKET) ? 16'(PIXELS_PER_PACKET) : 16'(rem_q);

        if (state_q != StIdle && frame_ready) pending_d = 1'b1;
        if (abort) pending_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!abort && (frame_ready || pending_q)) begin
                    state_d   = StWaitPhy;
                    ser_rst_d = 1'b1;
                    rem_d     = REM_W'(FRAME_PIXELS);
                    pkt_idx_d = '0;
                    pending_d = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            StWaitPhy, StPrime, StSend: begin
                if (abort) begin
                    state_d   = StGap;
                    cnt_d     = CNT_W'(IFG_CYCLES - 1);
                    rem_d     = '0;
                    aborted_d = 1'b1;
                end else if (state_q == StWaitPhy) begin
                    if (!phy_busy) begin
                        pkt_start_d = 1'b1;
                        pkt_len_d   = len_sel;
                        if (BRAM_LAT == 0) begin
                            state_d = StSend;
                            cnt_d   = send_load(len_sel);
                        end else begin
                            state_d = StPrime;
                            cnt_d   = CNT_W'(BRAM_LAT - 1);
                        end
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (state_q == StPrime) begin
                    state_d = StSend;
                    cnt_d   = send_load(pkt_len_q);
                end else begin
                    state_d = StGap;
                    cnt_d   = CNT_W'(IFG_CYCLES - 1);
                    rem_d   = rem_q - REM_W'(pkt_len_q);
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (aborted_q) begin
                    state_d = StIdle;
                end else if (rem_q != '0) begin
                    state_d   = StWaitPhy;
                    pkt_idx_d = pkt_idx_q + 16'd1;
                end else begin
                    // Pending requests are picked up from IDLE on the following edge.
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rem_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            aborted_q    <= 1'b0;
            pkt_len_q    <= '0;
            pkt_idx_q    <= '0;
            ser_rst_q    <= 1'b0;
            pkt_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ser_stall_q  <= 1'b1;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            aborted_q    <= aborted_d;
            pkt_len_q    <= pkt_len_d;
            pkt_idx_q    <= pkt_idx_d;
            ser_rst_q    <= ser_rst_d;
            pkt_start_q  <= pkt_start_d;
            frame_done_q <= frame_done_d;
            ser_stall_q  <= (state_d != StSend);
            tx_en_q      <= (state_d == StSend);
            busy_q       <= (state_d != StIdle);
        end
    end

    assign ser_stall  = ser_stall_q;
    assign ser_rst    = ser_rst_q;
    assign tx_en      = tx_en_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_idx    = pkt_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Scoreboard bench for eth_tx_scheduler: stimulus pushes expected events, negedge monitors
// reduce the DUT outputs to events (packet header, prime/window/gap lengths, frame done) and compare.
`timescale 1ns/1ps
module tb_eth_tx_scheduler;

    localparam int EV_SERRST = 0;
    localparam int EV_PKT    = 1;
    localparam int EV_PRIME  = 2;
    localparam int EV_WIN    = 3;
    localparam int EV_GAP    = 4;
    localparam int EV_DONE   = 5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_ready = 1'b0;
    logic phy_busy = 1'b0;
    logic abort = 1'b0;
    logic fr8 = 1'b0;

    logic        ser_stall, ser_rst, tx_en, pkt_start, frame_done, busy;
    logic [15:0] pkt_len, pkt_idx;
    logic        s8_stall, s8_rst, tx8, ps8, done8, busy8;
    logic [15:0] len8, idx8;

    ev_t q[$];
    ev_t q8[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    eth_tx_scheduler #(
        .FRAME_PIXELS(10), .PIXELS_PER_PACKET(4), .BRAM_LAT(2), .IFG_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .frame_ready(frame_ready), .phy_busy(phy_busy), .abort(abort),
        .ser_stall(ser_stall), .ser_rst(ser_rst), .tx_en(tx_en), .pkt_start(pkt_start),
        .pkt_len(pkt_len), .pkt_idx(pkt_idx), .frame_done(frame_done), .busy(busy)
    );

    eth_tx_scheduler #(
        .FRAME_PIXELS(8), .PIXELS_PER_PACKET(4), .BRAM_LAT(2), .IFG_CYCLES(3)
    ) dut8 (
        .clk(clk), .rst(rst), .frame_ready(fr8), .phy_busy(1'b0), .abort(1'b0),
        .ser_stall(s8_stall), .ser_rst(s8_rst), .tx_en(tx8), .pkt_start(ps8),
        .pkt_len(len8), .pkt_idx(idx8), .frame_done(done8), .busy(busy8)
    );

    function automatic string kname(input int k);
        case (k)
            EV_SERRST: return "ser_rst";
            EV_PKT:    return "pkt";
            EV_PRIME:  return "prime";
            EV_WIN:    return "window";
            EV_GAP:    return "gap";
            EV_DONE:   return "frame_done";
            default:   return "unknown";
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input bit sel8, input int kind, input int a, input int b);
        ev_t e;
        e.kind = 3'(kind);
        e.a    = 16'(a);
        e.b    = 16'(b);
        if (sel8) q8.push_back(e);
        else q.push_back(e);
    endtask

    task automatic observe(input bit sel8, input int kind, input int a, input int b);
        ev_t e;
        if ((sel8 && q8.size() == 0) || (!sel8 && q.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_%s%s: got a=%0d b=%0d, expected no event",
                     sel8 ? "dut8_" : "", kname(kind), a, b);
            return;
        end
        if (sel8) e = q8.pop_front();
        else e = q.pop_front();
        check({kname(int'(e.kind)), "_event_kind"}, kind, int'(e.kind));
        check({kname(kind), "_a"}, a, int'(e.a));
        check({kname(kind), "_b"}, b, int'(e.b));
    endtask

    // Packets of 4,4,2 pixels: 2 prime cycles, 16/16/8 tx cycles; gap to next pkt_start is
    // IFG + 1 WAIT_PHY cycle (plus any phy_busy hold), and IFG to frame_done after the last.
    task automatic push_frame(input int gap0);
        int lens[3] = '{4, 4, 2};
        push(1'b0, EV_SERRST, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(1'b0, EV_PKT, i, lens[i]);
            push(1'b0, EV_PRIME, 2, 0);
            push(1'b0, EV_WIN, lens[i] * 4, 0);
            push(1'b0, EV_GAP, (i == 0) ? gap0 : ((i == 1) ? 4 : 3), 0);
        end
        push(1'b0, EV_DONE, 40, 0);
    endtask

    int  win_cnt, prime_cnt, gap_cnt, total_tx, total8;
    bit  priming, in_gap;

    always @(negedge clk) begin
        if (!rst) begin
            win_cnt = 0; prime_cnt = 0; gap_cnt = 0; total_tx = 0;
            priming = 1'b0; in_gap = 1'b0;
        end else begin
            check("stall_xor_tx_en", int'(ser_stall ^ tx_en), 1);
            if (in_gap) begin
                if (pkt_start || frame_done || !busy) begin
                    observe(1'b0, EV_GAP, gap_cnt, 0);
                    in_gap = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            if (ser_rst) begin
                observe(1'b0, EV_SERRST, 0, 0);
                total_tx = 0;
            end
            if (pkt_start) begin
                observe(1'b0, EV_PKT, int'(pkt_idx), int'(pkt_len));
                priming = 1'b1;
                prime_cnt = 0;
            end
            if (tx_en) begin
                if (priming) begin
                    observe(1'b0, EV_PRIME, prime_cnt, 0);
                    priming = 1'b0;
                end
                win_cnt++;
                total_tx++;
            end else begin
                if (priming) prime_cnt++;
                if (win_cnt > 0) begin
                    observe(1'b0, EV_WIN, win_cnt, 0);
                    win_cnt = 0;
                    in_gap = 1'b1;
                    gap_cnt = 1;
                end
            end
            if (frame_done) observe(1'b0, EV_DONE, total_tx, 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            total8 = 0;
        end else begin
            if (s8_rst) total8 = 0;
            if (tx8) total8++;
            if (ps8) observe(1'b1, EV_PKT, int'(idx8), int'(len8));
            if (done8) observe(1'b1, EV_DONE, total8, 0);
        end
    end

    task automatic pulse_fr();
        @(negedge clk) frame_ready = 1'b1;
        @(negedge clk) frame_ready = 1'b0;
    endtask

    task automatic wait_tx(input string name);
        int n = 0;
        while (!tx_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(tx_en), 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0 || busy || busy8) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_events_left"}, q.size() + q8.size(), 0);
        if (q.size() != 0 || q8.size() != 0) begin
            q.delete();
            q8.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ser_stall", int'(ser_stall), 1);
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_ser_rst", int'(ser_rst), 0);
        check("rst_pkt_start", int'(pkt_start), 0);
        check("rst_pkt_len", int'(pkt_len), 0);
        check("rst_pkt_idx", int'(pkt_idx), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_busy_dut8", int'(busy8), 0);
        rst = 1'b1;

        // Plain frame.
        push_frame(4);
        pulse_fr();
        wait_drain("plain_frame");

        // phy_busy raised mid-SEND of packet 0 and held 5 WAIT_PHY cycles past the gap.
        push_frame(9);
        pulse_fr();
        wait_tx("phy_busy_wait_tx");
        repeat (4) @(negedge clk);
        phy_busy = 1'b1;
        n = 0;
        while (tx_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1 phy_busy = 1'b0;
        wait_drain("phy_busy_frame");

        // Abort sampled at the end of the 6th SEND cycle; a pending request is also dropped.
        push(1'b0, EV_SERRST, 0, 0);
        push(1'b0, EV_PKT, 0, 4);
        push(1'b0, EV_PRIME, 2, 0);
        push(1'b0, EV_WIN, 6, 0);
        push(1'b0, EV_GAP, 3, 0);
        pulse_fr();
        pulse_fr();
        wait_tx("abort_wait_tx");
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_drain("abort_frame");
        repeat (10) @(negedge clk);
        check("abort_clears_pending_busy", int'(busy), 0);

        // Two extra requests during frame 0 merge into one back-to-back frame.
        push_frame(4);
        push_frame(4);
        pulse_fr();
        repeat (10) @(negedge clk);
        pulse_fr();
        repeat (30) @(negedge clk);
        pulse_fr();
        n = 0;
        while (!frame_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("first_frame_done_seen", int'(frame_done), 1);
        @(negedge clk);
        check("ser_rst_after_frame_done", int'(ser_rst), 1);
        wait_drain("merged_frames");
        repeat (20) @(negedge clk);
        check("no_third_frame_busy", int'(busy), 0);

        // Reset mid-SEND, then a fresh frame from packet 0.
        push(1'b0, EV_SERRST, 0, 0);
        push(1'b0, EV_PKT, 0, 4);
        push(1'b0, EV_PRIME, 2, 0);
        pulse_fr();
        wait_tx("reset_wait_tx");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midsend_rst_ser_stall", int'(ser_stall), 1);
        check("midsend_rst_tx_en", int'(tx_en), 0);
        check("midsend_rst_busy", int'(busy), 0);
        check("midsend_rst_pkt_idx", int'(pkt_idx), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        push_frame(4);
        pulse_fr();
        wait_drain("after_reset_frame");

        // Frame that is an exact multiple of the packet size.
        push(1'b1, EV_PKT, 0, 4);
        push(1'b1, EV_PKT, 1, 4);
        push(1'b1, EV_DONE, 32, 0);
        @(negedge clk) fr8 = 1'b1;
        @(negedge clk) fr8 = 1'b0;
        wait_drain("exact_multiple_frame");
        repeat (10) @(negedge clk);
        check("exact_multiple_idle", int'(busy8), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
